// File: rtl/disp_pkg.sv
// Shared constants for the scanned result display: state encoding, glyphs and
// the active-low {g,f,e,d,c,b,a} hex decode table.
package disp_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SHOW = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [1:0] ST_DZ   = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_I     = 7'h79;
    localparam logic [6:0] SEG_V     = 7'h63;

    // Entry 0 is the rightmost element: index = nibble value.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/result_display_scan_if.sv
// ALU-result / display bundle between the ALU side (master) and the scanned
// display driver (slave).
interface result_display_scan_if;

    logic        result_valid;
    logic [31:0] result;
    logic        exception;
    logic        zeroDiv;
    logic [6:0]  seg;
    logic [7:0]  an;
    logic [1:0]  disp_state;

    modport master (
        output result_valid, result, exception, zeroDiv,
        input  seg, an, disp_state
    );

    modport slave (
        input  result_valid, result, exception, zeroDiv,
        output seg, an, disp_state
    );

endinterface

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment decode.
module hex_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_TABLE[i_nibble];

endmodule

// File: rtl/result_display_scan.sv
// Captures ALU results/flags and scans them onto an 8-digit active-low
// seven-segment display. Optional build macro: LEADING_ZERO_BLANK_EN.
module result_display_scan
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DIGITS      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    result_display_scan_if.slave disp
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    if (DIGITS != 8) begin : g_digits_check
        $error("result_display_scan: DIGITS must be 8");
    end
    if (REFRESH_DIV < 2) begin : g_div_check
        $error("result_display_scan: REFRESH_DIV must be >= 2");
    end

    logic [31:0]      r_held;
    logic [1:0]       r_state;
    logic [2:0]       r_idx;
    logic [CNT_W-1:0] r_div_cnt;
    logic [6:0]       r_seg_p1;
    logic [7:0]       r_an_p1;

    logic             w_tc;
    logic [3:0]       w_nibble;
    logic [6:0]       w_hex_seg;
    logic [6:0]       w_seg_next;
    logic [7:0]       w_an_next;

    assign w_tc = (r_div_cnt == CNT_W'(REFRESH_DIV - 1));

    // Refresh divider and digit index run in every state; captures never touch them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (w_tc) begin
            r_div_cnt <= '0;
            r_idx     <= r_idx + 3'd1;
        end else begin
            r_div_cnt <= r_div_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_held  <= '0;
            r_state <= ST_IDLE;
        end else if (disp.result_valid) begin
            r_held  <= disp.result;
            r_state <= disp.zeroDiv   ? ST_DZ  :
                       disp.exception ? ST_ERR : ST_SHOW;
        end
    end

    assign w_nibble = r_held[{r_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .i_nibble (w_nibble),
        .o_seg    (w_hex_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [7:0] w_upper_zero;
    always_comb begin
        w_upper_zero = '0;
        for (int k = 0; k < 8; k++) begin
            w_upper_zero[k] = ((r_held >> (4 * k)) == 32'd0);
        end
    end
`endif

    always_comb begin
        w_an_next  = ~(8'h01 << r_idx);
        w_seg_next = SEG_BLANK;
        case (r_state)
            ST_SHOW: begin
                w_seg_next = w_hex_seg;
`ifdef LEADING_ZERO_BLANK_EN
                if (r_idx != 3'd0 && w_upper_zero[r_idx]) begin
                    w_seg_next = SEG_BLANK;
                end
`endif
            end
            ST_ERR: begin
                case (r_idx)
                    3'd2:    w_seg_next = SEG_E;
                    3'd1:    w_seg_next = SEG_R;
                    3'd0:    w_seg_next = SEG_R;
                    default: w_seg_next = SEG_BLANK;
                endcase
            end
            ST_DZ: begin
                case (r_idx)
                    3'd3:    w_seg_next = SEG_D;
                    3'd2:    w_seg_next = SEG_I;
                    3'd1:    w_seg_next = SEG_V;
                    3'd0:    w_seg_next = HEX_TABLE[0];
                    default: w_seg_next = SEG_BLANK;
                endcase
            end
            default: begin
                w_an_next  = 8'hFF;
                w_seg_next = SEG_BLANK;
            end
        endcase
    end

    // Output stage: one cycle behind idx/state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_p1 <= SEG_BLANK;
            r_an_p1  <= 8'hFF;
        end else begin
            r_seg_p1 <= w_seg_next;
            r_an_p1  <= w_an_next;
        end
    end

    assign disp.seg        = r_seg_p1;
    assign disp.an         = r_an_p1;
    assign disp.disp_state = r_state;

endmodule
